bb_share_sched: RTL and testbench

Round-robin scheduler that time-shares one black-box operand port (`in1`/`in2`/`clk` style black-box cell) between N requesters. Each requester presents a 1-bit operand pair and a request. The scheduler grants one requester at a time and drives the shared black-box inputs for a fixed hold window. It then returns that requester's registered 1-bit sum/carry with a done pulse. It sits between the requester-side logic and the single black-box instance in the top level, so the netlist backend sees one shared cell instead of N.

---
 rtl/bb_share_sched.sv | 137 +++++++++++++
 tb/tb_bb_share_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bb_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bb_share_sched
//  Purpose  : Round-robin time-sharing of one black-box in1/in2 cell among N requesters.
//  Revision : 1.0  initial release
// ============================================================================
module bb_share_sched #(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] op_a_i,
    input  logic [N-1:0] op_b_i,
    output logic [N-1:0] gnt_o,
    output logic [N-1:0] done_o,
    output logic         sum_o,
    output logic         cout_o,
    output logic         bb_in1_o,
    output logic         bb_in2_o,
    output logic         bb_en_o,
    output logic         busy_o
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [PTR_W-1:0] C_LAST     = PTR_W'(N - 1);
    localparam logic [PTR_W:0]   C_N        = (PTR_W + 1)'(N);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     done_q;
    logic             sum_q;
    logic             cout_q;
    logic             bb_in1_q;
    logic             bb_in2_q;
    logic             bb_en_q;
    logic             busy_q;

    logic             found_d;
    logic [PTR_W-1:0] win_d;
    logic [PTR_W:0]   scan_d;

    // Scan upward from ptr with an explicit mod-N wrap so non-power-of-two N works.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        scan_d  = '0;
        for (int i = 0; i < N; i++) begin
            scan_d = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (scan_d >= C_N) begin
                scan_d = scan_d - C_N;
            end
            if (!found_d && req_i[scan_d[PTR_W-1:0]]) begin
                found_d = 1'b1;
                win_d   = scan_d[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            sum_q    <= 1'b0;
            cout_q   <= 1'b0;
            bb_in1_q <= 1'b0;
            bb_in2_q <= 1'b0;
            bb_en_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q    <= N'(1) << win_d;
                        win_q    <= win_d;
                        bb_in1_q <= op_a_i[win_d];
                        bb_in2_q <= op_b_i[win_d];
                        bb_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (cnt_q == C_CNT_LAST) begin
                        sum_q   <= bb_in1_q ^ bb_in2_q;
                        cout_q  <= bb_in1_q & bb_in2_q;
                        done_q  <= gnt_q;
                        bb_en_q <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    gnt_q    <= '0;
                    bb_in1_q <= 1'b0;
                    bb_in2_q <= 1'b0;
                    busy_q   <= 1'b0;
                    ptr_q    <= (win_q == C_LAST) ? '0 : win_q + PTR_W'(1);
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign sum_o    = sum_q;
    assign cout_o   = cout_q;
    assign bb_in1_o = bb_in1_q;
    assign bb_in2_o = bb_in2_q;
    assign bb_en_o  = bb_en_q;
    assign busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bb_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bb_share_sched
//  Purpose  : Directed scoreboard bench for the round-robin black-box scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bb_share_sched;

    localparam int N    = 4;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, op_a, op_b;
    logic [N-1:0] gnt, done;
    logic         sum, cout, bb_in1, bb_in2, bb_en, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         s;
        logic         c;
    } exp_t;

    exp_t sb[$];
    int   m_ptr;
    int   d0, d1, d2, d3;

    bb_share_sched #(.N(N), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .gnt_o    (gnt),
        .done_o   (done),
        .sum_o    (sum),
        .cout_o   (cout),
        .bb_in1_o (bb_in1),
        .bb_in2_o (bb_in2),
        .bb_en_o  (bb_en),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    task automatic idle_check(input string tag);
        chk({tag, "_gnt"},    gnt,    0);
        chk({tag, "_done"},   done,   0);
        chk({tag, "_bb_en"},  bb_en,  0);
        chk({tag, "_bb_in1"}, bb_in1, 0);
        chk({tag, "_bb_in2"}, bb_in2, 0);
        chk({tag, "_busy"},   busy,   0);
    endtask

    // Drive one request set from IDLE, follow it through SERVE/DONE, end on the IDLE cycle.
    task automatic service(input logic [N-1:0] r, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] ra, input logic [N-1:0] aa, input logic [N-1:0] ba,
                           output int done_cyc);
        int   w;
        exp_t e;
        logic la, lb;
        bit   got;
        req = r; op_a = a; op_b = b;
        w  = pick(r, m_ptr);
        la = a[w];
        lb = b[w];
        e.gnt = N'(1) << w;
        e.s   = la ^ lb;
        e.c   = la & lb;
        sb.push_back(e);
        done_cyc = 0;
        for (int k = 1; k <= HOLD; k++) begin
            @(negedge clk);
            chk("serve_gnt",    gnt,    e.gnt);
            chk("serve_bb_en",  bb_en,  1);
            chk("serve_bb_in1", bb_in1, la);
            chk("serve_bb_in2", bb_in2, lb);
            chk("serve_busy",   busy,   1);
            chk("serve_done",   done,   0);
            if (k == 1) begin
                req = ra; op_a = aa; op_b = ba;
            end
        end
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (done != 0) begin
                got      = 1;
                done_cyc = cyc;
                e        = sb.pop_front();
                chk("done_vec",  done,  e.gnt);
                chk("done_gnt",  gnt,   e.gnt);
                chk("done_sum",  sum,   e.s);
                chk("done_cout", cout,  e.c);
                chk("done_bben", bb_en, 0);
                chk("done_busy", busy,  1);
            end
        end
        chk("done_seen", got, 1);
        if (!got && sb.size() > 0) void'(sb.pop_front());
        m_ptr = (w == N - 1) ? 0 : w + 1;
        @(negedge clk);
        idle_check("post");
    endtask

    initial begin
        rst = 1'b1; req = '0; op_a = '0; op_b = '0;
        m_ptr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_check("reset");
        chk("reset_sum",  sum,  0);
        chk("reset_cout", cout, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_check("idle");
        end

        // Single request from requester 1 with a=b=1
        service(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, d0);
        @(negedge clk);
        idle_check("hold");
        chk("hold_sum",  sum,  0);
        chk("hold_cout", cout, 1);

        // Fairness from a fresh reset with all requesters held high
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        sb.delete();
        service(4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, d0);
        service(4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, d1);
        service(4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, d2);
        service(4'b1111, 4'b1010, 4'b0110, 4'b0000, 4'b1010, 4'b0110, d3);
        chk("rr_gap01", d1 - d0, HOLD + 2);
        chk("rr_gap12", d2 - d1, HOLD + 2);
        chk("rr_gap23", d3 - d2, HOLD + 2);

        // Wrap and skip: serve 2 alone, then 0101 must give 0 then 2
        service(4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, d0);
        service(4'b0101, 4'b0001, 4'b0101, 4'b0101, 4'b0001, 4'b0101, d0);
        service(4'b0101, 4'b0001, 4'b0101, 4'b0000, 4'b0001, 4'b0101, d0);

        // Mid-service request drop and operand flip are ignored
        service(4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, d0);
        chk("mid_sum",  sum,  1);
        chk("mid_cout", cout, 0);

        // Reset on the second SERVE cycle drops the request
        req = 4'b1111; op_a = 4'b1111; op_b = 4'b0000;
        @(negedge clk);
        chk("rstmid_gnt", gnt, 4'b0100);
        chk("rstmid_en",  bb_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_check("rstmid");
        chk("rstmid_sum",  sum,  0);
        chk("rstmid_cout", cout, 0);
        m_ptr = 0;
        sb.delete();
        service(4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, d0);

        repeat (3) @(negedge clk);
        idle_check("final");
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
